// File: rtl/mux_4_1_rr_v.sv
// Round-robin 4:1 valid/ready gatherer with a 1-entry registered output stage.
// Optional MUX_4_1_FORCE_SEL_EN adds i_force/i_sel_code to pin the grant to one lane.
module mux_4_1_rr_v #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [4*WIDTH-1:0] i_data,
    input  logic [3:0]         i_valid,
    output logic [3:0]         o_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_valid,
    input  logic               i_ready,
`ifdef MUX_4_1_FORCE_SEL_EN
    input  logic               i_force,
    input  logic [1:0]         i_sel_code,
`endif
    output logic [1:0]         o_sel_code
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;

    logic [3:0]         eligible;
    logic               loadEn;
    logic               grantFound;
    logic [1:0]         grantIdx;
    logic [1:0]         searchIdx;
    logic               accept;

    assign loadEn = (state_q == EMPTY) || i_ready;

`ifdef MUX_4_1_FORCE_SEL_EN
    assign eligible = i_force ? (i_valid & (4'b0001 << i_sel_code)) : i_valid;
`else
    assign eligible = i_valid;
`endif

    // First eligible lane starting at ptr, wrapping modulo 4.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = ptr_q;
        searchIdx  = ptr_q;
        for (int k = 0; k < 4; k++) begin
            searchIdx = ptr_q + 2'(k);
            if (!grantFound && eligible[searchIdx]) begin
                grantFound = 1'b1;
                grantIdx   = searchIdx;
            end
        end
    end

    // Reset masks the handshake so nothing is accepted while the word is being discarded.
    assign accept  = loadEn && grantFound && !i_rst;
    assign o_ready = accept ? (4'b0001 << grantIdx) : 4'b0000;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = FULL;
            data_d  = i_data[grantIdx*WIDTH +: WIDTH];
            sel_d   = grantIdx;
            ptr_d   = grantIdx + 2'd1;
        end else if (state_q == FULL && i_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_valid    = (state_q == FULL);
    assign o_data     = data_q;
    assign o_sel_code = sel_q;

endmodule
